// File: rtl/prince_pkg.sv
// prince_pkg: shared widths, FSM encoding and inverse S-box table for the PRINCE S-layer
package prince_pkg;
    localparam int STATE_W = 64;
    localparam int NIBBLES = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    // nibble x of this word holds S^-1(x)
    localparam logic [63:0] SINV_LUT = 64'h1CE5_046A_98DF_237B;
endpackage

// File: rtl/sbox_inv.sv
// sbox_inv: PRINCE 4-bit inverse S-box
module sbox_inv
    import prince_pkg::*;
(
    input  logic [3:0] x,
    output logic [3:0] y
);
    assign y = SINV_LUT[{x, 2'b00} +: 4];
endmodule

// File: rtl/prince_sinv_layer_seq.sv
// prince_sinv_layer_seq: PRINCE inverse S-layer, NIB_PER_CYC nibbles substituted per clock
module prince_sinv_layer_seq
    import prince_pkg::*;
#(
    parameter int NIB_PER_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);
    localparam int C  = NIBBLES / NIB_PER_CYC;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int SW = 4 * NIB_PER_CYC;
    localparam logic [CW-1:0] LAST = CW'(C - 1);

    if (!(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 ||
          NIB_PER_CYC == 8 || NIB_PER_CYC == 16)) begin : g_bad_param
        $error("NIB_PER_CYC must be 1, 2, 4, 8 or 16");
    end

    state_t             st, st_n;
    logic [CW-1:0]      cnt;
    logic [STATE_W-1:0] sreg, rotated;
    logic [SW-1:0]      sub;
    logic               accept;

    for (genvar i = 0; i < NIB_PER_CYC; i++) begin : g_sbox
        sbox_inv u_sbox (.x(sreg[4*i +: 4]), .y(sub[4*i +: 4]));
    end

    // substituted nibbles re-enter at the top so C rotations restore nibble order
    if (SW == STATE_W) begin : g_full
        assign rotated = sub;
    end else begin : g_rot
        assign rotated = {sub, sreg[STATE_W-1:SW]};
    end

    assign in_ready  = (st == IDLE) || (st == DONE && out_ready);
    assign out_valid = (st == DONE);
    assign busy      = (st == RUN);
    assign out_state = sreg;
    assign accept    = in_valid && in_ready;

    always_comb begin
        st_n = st;
        case (st)
            IDLE:    st_n = accept ? RUN : IDLE;
            RUN:     st_n = (cnt == LAST) ? DONE : RUN;
            DONE:    st_n = out_ready ? (in_valid ? RUN : IDLE) : DONE;
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            cnt  <= '0;
            sreg <= '0;
        end else begin
            st <= st_n;
            if (accept) begin
                sreg <= in_state;
                cnt  <= '0;
            end else if (st == RUN) begin
                sreg <= rotated;
                cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prince_sinv_layer_seq.sv
// tb_prince_sinv_layer_seq: checks every legal NIB_PER_CYC against a transaction-level model
module tb_prince_sinv_layer_seq;
    logic clk;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] si_t [16] = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                              4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
    logic [3:0] sf_t [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                              4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] slayer(input logic [63:0] v, input bit inv);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[4*i +: 4] = inv ? si_t[v[4*i +: 4]] : sf_t[v[4*i +: 4]];
        return r;
    endfunction

    task automatic chk(input int n, input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL n%0d %s got %h exp %h", n, nm, got, exp);
        end
    endtask

    for (genvar p = 0; p < 5; p++) begin : g
        localparam int N = 1 << p;
        localparam int C = 16 / N;
        logic        rst, in_valid, in_ready, out_valid, out_ready, busy, fin;
        logic [63:0] in_state, out_state;
        bit          full, zero, acc, armed = 0;
        int          remain;
        logic [63:0] exp_out, src;

        prince_sinv_layer_seq #(.NIB_PER_CYC(N)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
            .in_state(in_state), .out_valid(out_valid), .out_ready(out_ready),
            .out_state(out_state), .busy(busy)
        );

        // model: one block in flight, result appears C edges after acceptance
        always @(posedge clk) begin
            if (rst) begin
                full = 0; remain = 0; zero = 1; armed = 1;
            end else begin
                acc = in_valid && (!full || (remain == 0 && out_ready));
                if (full && remain == 0 && out_ready) full = 0;
                else if (full && remain > 0) remain--;
                if (acc) begin
                    full = 1; remain = C; zero = 0;
                    src = in_state; exp_out = slayer(in_state, 1);
                end
            end
        end

        always @(negedge clk) if (armed) begin
            chk(N, "in_ready", 64'(in_ready), 64'(!full || (remain == 0 && out_ready)));
            chk(N, "out_valid", 64'(out_valid), 64'(full && remain == 0));
            chk(N, "busy", 64'(busy), 64'(full && remain > 0));
            if (full && remain == 0) begin
                chk(N, "out_state", out_state, exp_out);
                chk(N, "round_trip", slayer(out_state, 0), src);
            end
            if (zero) chk(N, "out_state_reset", out_state, 64'h0);
        end

        task automatic wait_valid(output int n);
            n = 0;
            @(negedge clk);
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
        endtask

        task automatic xfer(input logic [63:0] v, input logic [63:0] e, input string nm);
            int n;
            @(posedge clk); #1;
            in_valid = 1; in_state = v; out_ready = 1;
            @(posedge clk); #1;
            in_valid = 0;
            wait_valid(n);
            chk(N, {nm, "_latency"}, 64'(n), 64'(C));
            chk(N, nm, out_state, e);
        endtask

        task automatic idle_after_reset(input string nm);
            chk(N, {nm, "_out_valid"}, 64'(out_valid), 64'h0);
            chk(N, {nm, "_in_ready"}, 64'(in_ready), 64'h1);
            chk(N, {nm, "_busy"}, 64'(busy), 64'h0);
            chk(N, {nm, "_out_state"}, out_state, 64'h0);
        endtask

        initial begin
            int n;
            fin = 0; rst = 1; in_valid = 0; out_ready = 0; in_state = '0;
            repeat (2) @(posedge clk);
            #1 rst = 0;
            @(negedge clk);
            idle_after_reset("rst");
            xfer(64'h0123456789ABCDEF, 64'hB732FD89A6405EC1, "t1");
            xfer(64'h0, 64'hBBBBBBBBBBBBBBBB, "t2_zero");
            xfer(64'hFFFFFFFFFFFFFFFF, 64'h1111111111111111, "t2_ones");
            // back-to-back: second block accepted on the edge that hands off the first
            @(posedge clk); #1;
            in_valid = 1; in_state = 64'h0123456789ABCDEF; out_ready = 1;
            @(posedge clk); #1;
            in_state = 64'hFEDCBA9876543210;
            wait_valid(n);
            chk(N, "t3_first_latency", 64'(n), 64'(C));
            chk(N, "t3_first", out_state, 64'hB732FD89A6405EC1);
            @(posedge clk); #1;
            in_valid = 0;
            n = 0;
            @(negedge clk);
            chk(N, "t3_no_bubble", 64'(busy), 64'h1);
            while (!out_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk(N, "t3_second_spacing", 64'(n + 1), 64'(C + 1));
            chk(N, "t3_second", out_state, 64'h1CE5046A98DF237B);
            @(posedge clk); #1;
            in_valid = 1; in_state = 64'h0123456789ABCDEF; out_ready = 0;
            @(posedge clk); #1;
            in_state = 64'hFEDCBA9876543210;
            wait_valid(n);
            repeat (10) begin
                chk(N, "t4_hold_state", out_state, 64'hB732FD89A6405EC1);
                chk(N, "t4_hold_valid", 64'(out_valid), 64'h1);
                chk(N, "t4_in_ready", 64'(in_ready), 64'h0);
                @(negedge clk);
            end
            @(posedge clk); #1;
            out_ready = 1; in_valid = 0;
            @(posedge clk); #1;
            @(negedge clk);
            chk(N, "t4_single_xfer", 64'(out_valid), 64'h0);
            chk(N, "t4_no_new_block", 64'(busy), 64'h0);
            @(posedge clk); #1;
            in_valid = 1; in_state = 64'h0123456789ABCDEF; out_ready = 1;
            @(posedge clk); #1;
            in_valid = 0;
            @(posedge clk); #1;
            rst = 1;
            @(posedge clk); #1;
            rst = 0;
            @(negedge clk);
            idle_after_reset("t5");
            xfer(64'hFEDCBA9876543210, 64'h1CE5046A98DF237B, "t5_after");
            repeat (1500) begin
                @(posedge clk); #1;
                rst = ($urandom_range(0, 99) == 0);
                in_valid = 1'($urandom_range(0, 1));
                in_state = {$urandom, $urandom};
                out_ready = ($urandom_range(0, 3) != 0);
            end
            @(posedge clk); #1;
            rst = 0; in_valid = 0; out_ready = 1;
            repeat (40) @(posedge clk);
            fin = 1;
        end
    end

    initial begin
        int k = 0;
        while (!(g[0].fin && g[1].fin && g[2].fin && g[3].fin && g[4].fin) && k < 20000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 20000) begin
            errors++;
            $display("FAIL timeout after %0d cycles, required completion", k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
